// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage RISC-V pipeline plus the
// MEM/WB pipeline register.
//   clk, rst            pipeline clock, synchronous active-high reset
//   *M inputs           EX/MEM bundle (control, address, store data, passthroughs)
//   dmem_*              ready-handshaked data-memory port (word address, lane
//                       replicated write data, byte strobes)
//   StallM              holds IF..M while an access is outstanding
//   *W outputs          registered write-back bundle and fault flags
//
// state  | meaning
// S_IDLE | no access outstanding; a new access issues here
// S_WAIT | request held, counting cycles toward the timeout abort
module mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ValidM,
   input  logic        RegWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic        MemWriteM,
   input  logic        MemReadM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  RdM,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] ImmExtM,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   output logic        StallM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUResultW,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ImmExtW,
   output logic [4:0]  RdW,
   output logic        MisalignW,
   output logic        BusErrW
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            reg_write_w_q, reg_write_w_d;
   logic [1:0]      result_src_w_q, result_src_w_d;
   logic [31:0]     read_data_w_q, read_data_w_d;
   logic [31:0]     alu_result_w_q, alu_result_w_d;
   logic [31:0]     pc_plus4_w_q, pc_plus4_w_d;
   logic [31:0]     imm_ext_w_q, imm_ext_w_d;
   logic [4:0]      rd_w_q, rd_w_d;
   logic            misalign_w_q, misalign_w_d;
   logic            bus_err_w_q, bus_err_w_d;

   logic            access, is_load, is_store, bad_f3, misal, fault;
   logic            abort, complete;
   logic [1:0]      a;
   logic [3:0]      strb;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [31:0]     ld_fmt;

   // access decode, lane generation and load formatting
   always_comb begin
      a        = ALUResultM[1:0];
      is_load  = MemReadM;
      is_store = MemWriteM & ~MemReadM;
      access   = ValidM & (MemReadM | MemWriteM);
      if (is_load)
         bad_f3 = (Funct3M == 3'b011) || (Funct3M[2:1] == 2'b11);
      else
         bad_f3 = Funct3M[2] | (Funct3M[1:0] == 2'b11);
      misal = ((Funct3M[1:0] == 2'b01) & a[0]) |
              ((Funct3M[1:0] == 2'b10) & (a != 2'b00));
      fault = access & (bad_f3 | misal);

      strb       = 4'b1111;
      dmem_wdata = WriteDataM;
      case (Funct3M[1:0])
         2'b00: begin
            strb       = 4'b0001 << a;
            dmem_wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            strb       = 4'b0011 << {a[1], 1'b0};
            dmem_wdata = {2{WriteDataM[15:0]}};
         end
         default: ;
      endcase

      case (a)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (Funct3M)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_fmt = {24'd0, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_fmt = {16'd0, ld_half};
         default: ld_fmt = dmem_rdata;
      endcase
   end

   // handshake outputs; reset masks the request even mid-WAIT
   always_comb begin
      dmem_req   = ~rst & ((state_q == S_WAIT) | (access & ~fault));
      dmem_we    = dmem_req & is_store;
      dmem_wstrb = (dmem_req & is_store) ? strb : 4'b0000;
      dmem_addr  = {ALUResultM[31:2], 2'b00};
      // a ready in the last WAIT cycle wins over the timeout
      abort      = (state_q == S_WAIT) & ~dmem_ready & (cnt_q == CW'(TIMEOUT));
      complete   = dmem_req & dmem_ready;
      StallM     = dmem_req & ~dmem_ready & ~abort;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (dmem_req & ~dmem_ready) begin
               state_d = S_WAIT;
               cnt_d   = CW'(1);
            end
         end
         S_WAIT: begin
            if (dmem_ready | abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // MEM/WB next value; a stall inserts a bubble and holds the data fields
   always_comb begin
      reg_write_w_d  = reg_write_w_q;
      result_src_w_d = result_src_w_q;
      read_data_w_d  = read_data_w_q;
      alu_result_w_d = alu_result_w_q;
      pc_plus4_w_d   = pc_plus4_w_q;
      imm_ext_w_d    = imm_ext_w_q;
      rd_w_d         = rd_w_q;
      misalign_w_d   = misalign_w_q;
      bus_err_w_d    = bus_err_w_q;
      if (StallM) begin
         reg_write_w_d = 1'b0;
         misalign_w_d  = 1'b0;
         bus_err_w_d   = 1'b0;
      end else begin
         reg_write_w_d  = ValidM & RegWriteM & ~fault & ~abort;
         result_src_w_d = ResultSrcM;
         read_data_w_d  = (access & is_load & complete) ? ld_fmt : 32'd0;
         alu_result_w_d = ALUResultM;
         pc_plus4_w_d   = PCPlus4M;
         imm_ext_w_d    = ImmExtM;
         rd_w_d         = RdM;
         misalign_w_d   = fault;
         bus_err_w_d    = abort;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         reg_write_w_q  <= 1'b0;
         result_src_w_q <= 2'b00;
         read_data_w_q  <= '0;
         alu_result_w_q <= '0;
         pc_plus4_w_q   <= '0;
         imm_ext_w_q    <= '0;
         rd_w_q         <= '0;
         misalign_w_q   <= 1'b0;
         bus_err_w_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         reg_write_w_q  <= reg_write_w_d;
         result_src_w_q <= result_src_w_d;
         read_data_w_q  <= read_data_w_d;
         alu_result_w_q <= alu_result_w_d;
         pc_plus4_w_q   <= pc_plus4_w_d;
         imm_ext_w_q    <= imm_ext_w_d;
         rd_w_q         <= rd_w_d;
         misalign_w_q   <= misalign_w_d;
         bus_err_w_q    <= bus_err_w_d;
      end
   end

   assign RegWriteW  = reg_write_w_q;
   assign ResultSrcW = result_src_w_q;
   assign ReadDataW  = read_data_w_q;
   assign ALUResultW = alu_result_w_q;
   assign PCPlus4W   = pc_plus4_w_q;
   assign ImmExtW    = imm_ext_w_q;
   assign RdW        = rd_w_q;
   assign MisalignW  = misalign_w_q;
   assign BusErrW    = bus_err_w_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline, together with its MEM/WB pipeline register. It takes the EX/MEM bundle and performs loads and stores over a ready-handshaked data-memory port. Loads are byte/half/word aligned and extended. The stage stalls the upstream pipe while an access is outstanding, then registers the results that the write-back stage selects from.

## Interface
Parameters:
- TIMEOUT, 16: max cycles in WAIT before an access is aborted (≥1).

Ports (clock and reset first):
- clk  in  1  pipeline clock.
- rst  in  1  reset; synchronous, active-high, sampled on rising clk.
- ValidM  in  1  M-stage holds a real instruction (0 = bubble).
- RegWriteM  in  1  register write enable.
- ResultSrcM  in  2  WB select (00 ALU, 01 load, 10 PC+4, 11 imm).
- MemWriteM  in  1  store.
- MemReadM  in  1  load.
- Funct3M  in  3  access size/sign.
- ALUResultM  in  32  effective address / ALU result.
- WriteDataM  in  32  store data (rs2).
- RdM  in  5  destination register.
- PCPlus4M, ImmExtM  in  32 each  passthrough.
- dmem_rdata  in  32  read word.
- dmem_ready  in  1  access complete this cycle.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  {ALUResultM[31:2], 2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte strobes (0 on loads).
- StallM  out  1  hold IF..M stages this cycle.
- RegWriteW, ResultSrcW[2], ReadDataW[32], ALUResultW[32], PCPlus4W[32], ImmExtW[32], RdW[5]  out  registered WB bundle.
- MisalignW  out  1  registered: instruction in W was a faulting access.
- BusErrW  out  1  registered: instruction in W was aborted by timeout.

## Operation
- Access = ValidM & (MemReadM | MemWriteM); MemReadM takes priority if both are set.
- Fault = access with LH/LHU/SH and addr[0]=1, LW/SW and addr[1:0]≠0, or a load with Funct3 ∈ {011,110,111} or store with Funct3 ∉ {000,001,010}. A faulting access issues no dmem_req.
- Store lanes: SB gives wstrb=0001<<a[1:0] and wdata={4{byte}}. SH gives wstrb=0011<<{a[1],1'b0} and wdata={2{half}}. SW gives wstrb=1111.
- Load format, byte/half picked by a[1:0]/a[1]: LB sign-extends, LBU zero-extends, LH sign-extends, LHU zero-extends, LW passes through.
- FSM:
  - IDLE: access & no fault drives dmem_req=1. Ready → complete, stay IDLE. No ready → WAIT, cnt=1.
  - WAIT: dmem_req=1 with address/data held from the M inputs, which are stable under stall. Ready → complete, go IDLE. Else, when cnt==TIMEOUT → abort, go IDLE. Else cnt+1.
- StallM = dmem_req & ~dmem_ready & ~abort.
- MEM/WB register update on every rising clk:
  - StallM=1: loads a bubble (RegWriteW=0, flags 0; other fields don't-care, left held).
  - Complete or non-access: loads the M bundle, ReadDataW = formatted load (0 for non-loads).
  - Fault: loads the bundle with RegWriteW=0, MisalignW=1.
  - Abort: loads the bundle with RegWriteW=0, BusErrW=1.
  - ValidM=0: loads RegWriteW=0.
- Reset: state IDLE, cnt 0, and every W output 0 (ResultSrcW=00). dmem_req, dmem_we, dmem_wstrb and StallM are 0 while rst is high, including mid-WAIT.

## Timing
- Zero-wait memory (ready in the request cycle): no stall; the result appears at the W outputs one clk after the M inputs.
- N wait cycles: StallM is high for N cycles; the W outputs update at the edge ending the ready cycle.
- Timeout: dmem_req is held for TIMEOUT+1 cycles total (IDLE cycle plus TIMEOUT WAIT cycles). BusErrW is set on the following edge. A ready arriving in the abort cycle counts as completion, not an abort.
- dmem_req, dmem_addr, dmem_wdata and dmem_wstrb are combinational from the M inputs and state, and stay stable until ready.
- W outputs change only on rising clk.

## Test plan
- LB at addr 0x103, rdata=0x80FF_1234, zero-wait → no stall; next cycle ReadDataW=0xFFFF_FF80 and RegWriteW=1. LBU on the same access gives 0x0000_0080.
- SH at addr 0x202 with data 0x0000_BEEF → dmem_addr=0x200, wstrb=1100, wdata=0xBEEF_BEEF, we=1; RegWriteW=0 next cycle.
- LW at addr 0x40 with ready delayed 3 cycles → StallM=1 for exactly 3 cycles with bubbles in W; then ReadDataW=rdata and RdW=RdM.
- LW at addr 0x42 → no dmem_req, no stall; next cycle MisalignW=1, RegWriteW=0.
- TIMEOUT=4, ready never arrives → dmem_req high 5 cycles, then drops; next cycle BusErrW=1, StallM=0, state IDLE.
- rst pulse in the 2nd WAIT cycle → dmem_req=0 the same cycle. After reset all W outputs are 0. A following zero-wait LW completes normally.
